// File: rtl/adder_subtractor.sv
// adder_subtractor: registered 4-bit ripple-carry adder/subtractor.
//
// Operands are bit-split on individual ports. With ctrl=0 the result is A+B, and with
// ctrl=1 it is A-B. Subtraction inverts B and injects a carry-in of 1, which gives the
// two's complement. The result, carry and flags are captured on every clock edge where
// in_valid is high, and are held on all other edges. out_valid pulses for one cycle per
// captured result.
//
// Optional feature: define ADDER_SUBTRACTOR_FLAGS_EN to add the v (signed overflow) and
// z (zero) outputs. The default build has no flag ports.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; release is expected synchronous to clk
//   a0..a3     operand A, a0 = LSB
//   b0..b3     operand B, b0 = LSB
//   ctrl       0 = add, 1 = subtract; sampled together with the operands
//   in_valid   capture operands on this edge
//   s0..s3     registered result, s0 = LSB
//   c          registered carry-out (subtract: 1 = no borrow)
//   out_valid  one-cycle strobe marking a new result
//   v, z       registered overflow / zero flags (ADDER_SUBTRACTOR_FLAGS_EN only)
module adder_subtractor (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic ctrl,
  input  logic in_valid,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic c,
  output logic out_valid
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
  ,
  output logic v,
  output logic z
`endif
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_bx;
  logic [3:0] w_sum;
  logic [4:0] w_carry;

  logic [3:0] r_sum;
  logic       r_c;
  logic       r_valid;

  assign w_a  = {a3, a2, a1, a0};
  assign w_b  = {b3, b2, b1, b0};
  assign w_bx = w_b ^ {4{ctrl}};

  // Ripple chain. In subtract mode, ctrl supplies the +1 of the two's complement.
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = ctrl;
    for (int i = 0; i < 4; i++) begin
      w_sum[i]       = w_a[i] ^ w_bx[i] ^ w_carry[i];
      w_carry[i + 1] = (w_a[i] & w_bx[i]) | (w_carry[i] & (w_a[i] ^ w_bx[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum <= w_sum;
        r_c   <= w_carry[4];
      end
    end
  end

`ifdef ADDER_SUBTRACTOR_FLAGS_EN
  logic r_v;
  logic r_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_z <= 1'b0;
    end else if (in_valid) begin
      // Signed overflow: the carry into the MSB stage disagrees with the carry out of it.
      r_v <= w_carry[3] ^ w_carry[4];
      r_z <= (w_sum == 4'b0000);
    end
  end

  assign v = r_v;
  assign z = r_z;
`endif

  assign s0        = r_sum[0];
  assign s1        = r_sum[1];
  assign s2        = r_sum[2];
  assign s3        = r_sum[3];
  assign c         = r_c;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor. An arithmetic model pushes the expected
// results into a scoreboard queue, and each test pops from it when out_valid appears.
module tb_adder_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
  logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
  logic ctrl = 1'b0;
  logic in_valid = 1'b0;
  logic s0, s1, s2, s3, c, out_valid;
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
  logic v, z;
`endif
  logic [3:0] s_obs;

  assign s_obs = {s3, s2, s1, s0};

  always #5 clk = ~clk;

  adder_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .ctrl      (ctrl),
    .in_valid  (in_valid),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .c         (c),
    .out_valid (out_valid)
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
    ,
    .v         (v),
    .z         (z)
`endif
  );

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic [4:0] t;
    exp_t e;
    if (!op) t = {1'b0, a} + {1'b0, b};
    else     t = {1'b0, a} + {1'b0, ~b} + 5'd1;
    e.s = t[3:0];
    e.c = t[4];
    e.v = op ? ((a[3] != b[3]) && (t[3] != a[3])) : ((a[3] == b[3]) && (t[3] != a[3]));
    e.z = (t[3:0] == 4'd0);
    return e;
  endfunction

  // Drive at the falling edge, let the rising edge sample, then return 1 ns later.
  task automatic drive_op(input logic [3:0] a, input logic [3:0] b, input logic op,
                          input logic valid);
    @(negedge clk);
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    ctrl     = op;
    in_valid = valid;
    if (valid && rst_n) sb_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if ({c, s_obs} !== 5'b0) begin
      failures++; $display("FAIL reset_sc got=%b want=00000", {c, s_obs});
    end
    // Operands offered during reset must not be captured.
    drive_op(4'hF, 4'hF, 1'b0, 1'b1);
    checks++;
    if ({out_valid, c, s_obs} !== 6'b0) begin
      failures++; $display("FAIL reset_held got=%b want=000000", {out_valid, c, s_obs});
    end
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
    checks++;
    if ({v, z} !== 2'b00) begin
      failures++; $display("FAIL reset_flags got=%b want=00", {v, z});
    end
`endif
    #2 rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [8:0] vec [7];
    exp_t e;
    // {a, b, ctrl}
    vec = '{{4'b0101, 4'b0011, 1'b0}, {4'b1001, 4'b1001, 1'b0}, {4'b1111, 4'b0001, 1'b0},
            {4'b0111, 4'b0011, 1'b1}, {4'b0011, 4'b0111, 1'b1}, {4'b0000, 4'b0000, 1'b1},
            {4'b1000, 4'b0001, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      drive_op(vec[i][8:5], vec[i][4:1], vec[i][0], 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL vec%0d_out_valid got=%b want=1", i, out_valid);
      end
      checks++;
      if (sb_q.size() == 0) begin
        failures++; $display("FAIL vec%0d_scoreboard got=empty want=entry", i);
      end else begin
        e = sb_q.pop_front();
        last_exp = e;
        checks++;
        if ({c, s_obs} !== {e.c, e.s}) begin
          failures++; $display("FAIL vec%0d_sc got=%b want=%b", i, {c, s_obs}, {e.c, e.s});
        end
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
        checks++;
        if ({v, z} !== {e.v, e.z}) begin
          failures++; $display("FAIL vec%0d_flags got=%b want=%b", i, {v, z}, {e.v, e.z});
        end
`endif
      end
      // Drop out_valid between vectors to confirm it is a single-cycle strobe.
      drive_op(4'h0, 4'h0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL vec%0d_strobe got=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive_op((i % 2 == 0) ? 4'hA : 4'h5, (i % 2 == 0) ? 4'h5 : 4'hA, i[0] ? 1'b0 : 1'b1,
               1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL hold%0d_out_valid got=%b want=0", i, out_valid);
      end
      checks++;
      if ({c, s_obs} !== {last_exp.c, last_exp.s}) begin
        failures++;
        $display("FAIL hold%0d_sc got=%b want=%b", i, {c, s_obs}, {last_exp.c, last_exp.s});
      end
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
      checks++;
      if ({v, z} !== {last_exp.v, last_exp.z}) begin
        failures++;
        $display("FAIL hold%0d_flags got=%b want=%b", i, {v, z}, {last_exp.v, last_exp.z});
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      drive_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL b2b%0d_out_valid got=%b want=1", i, out_valid);
      end
      checks++;
      if (sb_q.size() == 0) begin
        failures++; $display("FAIL b2b%0d_scoreboard got=empty want=entry", i);
      end else begin
        e = sb_q.pop_front();
        last_exp = e;
        checks++;
        if ({c, s_obs} !== {e.c, e.s}) begin
          failures++; $display("FAIL b2b%0d_sc got=%b want=%b", i, {c, s_obs}, {e.c, e.s});
        end
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
        checks++;
        if ({v, z} !== {e.v, e.z}) begin
          failures++; $display("FAIL b2b%0d_flags got=%b want=%b", i, {v, z}, {e.v, e.z});
        end
`endif
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive_op(4'h3, 4'h4, 1'b0, 1'b1);
    drive_op(4'h9, 4'h2, 1'b1, 1'b1);
    // Pull reset between edges while a result is on the outputs.
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if ({out_valid, c, s_obs} !== 6'b0) begin
      failures++; $display("FAIL mid_async got=%b want=000000", {out_valid, c, s_obs});
    end
`ifdef ADDER_SUBTRACTOR_FLAGS_EN
    checks++;
    if ({v, z} !== 2'b00) begin
      failures++; $display("FAIL mid_async_flags got=%b want=00", {v, z});
    end
`endif
    drive_op(4'h7, 4'h1, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_in_reset got=%b want=0", out_valid);
    end
    #2 rst_n = 1'b1;
    drive_op(4'h1, 4'h1, 1'b0, 1'b0);
    checks++;
    if ({out_valid, c, s_obs} !== 6'b0) begin
      failures++; $display("FAIL mid_idle got=%b want=000000", {out_valid, c, s_obs});
    end
    drive_op(4'h6, 4'h7, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_first_out_valid got=%b want=1", out_valid);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL mid_first_scoreboard got=empty want=entry");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if ({c, s_obs} !== {e.c, e.s}) begin
        failures++; $display("FAIL mid_first_sc got=%b want=%b", {c, s_obs}, {e.c, e.s});
      end
    end
    drive_op(4'h0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_strobe got=%b want=0", out_valid);
    end
  endtask

  initial begin
    last_exp = '0;
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_hold();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
